// File: rtl/sd_stream_ctrl.sv
// Frame sequencer for the sdmoore detector: serializes byte frames MSB-first onto
// sd_din, holds the detector in reset between frames and counts its match pulses.
//
// state | meaning
// IDLE  | detector held in reset, waiting for start
// LOAD  | detector held in reset, waiting for the first byte of the frame
// SHIFT | one bit per clock onto sd_din, next byte taken at bit 0
// DRAIN | sd_din = 0 for DET_LAT clocks while in-flight matches arrive
// DONE  | one-cycle frame_done / frame_err report
module sd_stream_ctrl #(
    parameter int FRAME_BYTES = 5,
    parameter int DET_LAT     = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             sd_din,
    output logic             sd_reset,
    input  logic             sd_dout,
    output logic [CNT_W-1:0] match_count,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int DL_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_BYTES - 1);
    localparam logic [DL_W-1:0] DRAIN_TC = DL_W'(DET_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         shreg;
    logic [2:0]         bit_idx;
    logic [BC_W-1:0]    bytes_left;
    logic [DL_W-1:0]    drain_cnt;
    logic               err;
    logic [DET_LAT-1:0] tag_pipe;
    logic               load_byte;
    logic               underrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        byte_ready = 1'b0;
        sd_din     = 1'b0;
        sd_reset   = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        load_byte  = 1'b0;
        underrun   = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                sd_reset = 1'b1;
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sd_reset   = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) begin
                    load_byte = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sd_din = shreg[bit_idx];
                if (bit_idx == 3'd0) begin
                    if (bytes_left == '0) begin
                        state_nxt = DRAIN;
                    end else begin
                        byte_ready = 1'b1;
                        if (byte_valid) begin
                            load_byte = 1'b1;
                        end else begin
                            underrun  = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                frame_err  = err;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            bit_idx     <= '0;
            bytes_left  <= '0;
            drain_cnt   <= DRAIN_TC;
            err         <= 1'b0;
            tag_pipe    <= '0;
            match_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                bytes_left <= '0;
                bit_idx    <= '0;
                err        <= 1'b0;
            end

            if (load_byte) begin
                shreg      <= byte_data;
                bit_idx    <= 3'd7;
                bytes_left <= (state == LOAD) ? LAST_IDX : bytes_left - 1'b1;
            end else if (state == SHIFT) begin
                bit_idx <= bit_idx - 1'b1;
            end

            if (underrun) begin
                err <= 1'b1;
            end

            // drain timer is a down-counter reloaded whenever we are not draining
            if (state != DRAIN) begin
                drain_cnt <= DRAIN_TC;
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            // tag marks cycles where SHIFT drove a real bit; its tail lines up with sd_dout
            tag_pipe <= (tag_pipe << 1) | DET_LAT'(state == SHIFT);

            if (state == IDLE && start) begin
                match_count <= '0;
            end else if (tag_pipe[DET_LAT-1] && sd_dout && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
Frame sequencer for the Moore sequence detector (sdmoore).
- Accepts bytes from an upstream source over a valid/ready handshake.
- Serializes each frame of FRAME_BYTES bytes MSB-first, one bit per clock, onto the detector's din.
- Holds the detector in reset between frames.
- Counts detector dout pulses over each frame and reports the count with a done pulse.
- Sits between the byte-stream producer and the detector; it is the only driver of the detector's din and reset.

Parameters:
FRAME_BYTES  5  bytes per frame (>=1)
DET_LAT      1  clocks from a bit on sd_din to the matching sd_dout (>=1)
CNT_W        8  width of match_count

Ports:
clk          in   1      clock, rising edge
reset        in   1      synchronous, active-high
start        in   1      begin a frame; sampled only in IDLE
busy         out  1      high in every state except IDLE
byte_valid   in   1      upstream byte available
byte_data    in   8      upstream byte
byte_ready   out  1      controller accepts byte_data this cycle
sd_din       out  1      serial bit to detector din
sd_reset     out  1      detector reset
sd_dout      in   1      detector dout
match_count  out  CNT_W  matches in last frame; held until next start
frame_done   out  1      one-cycle pulse at end of frame
frame_err    out  1      valid with frame_done; 1 = underrun abort

Behaviour:
Reset (synchronous) values:
- state = IDLE, busy = 0, byte_ready = 0, sd_din = 0, sd_reset = 1.
- match_count = 0, frame_done = 0, frame_err = 0.
- Reset asserted mid-frame aborts immediately: no frame_done, counters cleared.

State machine:
- IDLE
  - sd_reset = 1.
  - start = 1 -> LOAD next cycle; clears match_count, byte counter and bit index.
- LOAD
  - sd_reset = 1, byte_ready = 1.
  - Waits indefinitely for byte_valid; no detector bits are consumed.
  - On handshake: shift register <= byte_data, bit index <= 7, go to SHIFT.
- SHIFT
  - sd_reset = 0; sd_din = shreg[bit index], driven from registers.
  - Bit index decrements 7..0 each cycle.
  - byte_ready = 1 only in the cycle where bit index = 0 and this is not the last byte.
  - In that cycle, byte_valid = 1 loads the next byte, so the next cycle carries its bit 7 with no gap.
  - In that cycle, byte_valid = 0 is an underrun: set err flag, go to DRAIN.
  - After bit 0 of the last byte, go to DRAIN.
  - A normal frame spends exactly 8*FRAME_BYTES cycles in SHIFT.
- DRAIN
  - sd_reset = 0, sd_din = 0, for DET_LAT cycles, to collect in-flight detector outputs.
  - Then go to DONE.
- DONE
  - frame_done = 1 and frame_err = err flag for one cycle.
  - Next cycle: IDLE (sd_reset = 1).

Handshake and control rules:
- byte_ready is 0 in IDLE, DRAIN and DONE.
- start is ignored while busy.
- byte_valid is ignored whenever byte_ready = 0.

Match counting:
- A DET_LAT-deep shift pipeline tags every cycle in which SHIFT drove a bit.
- When a tagged cycle emerges from the pipeline with sd_dout = 1, match_count increments.
- Bits driven in DRAIN, LOAD or IDLE are never counted.
- match_count saturates at 2^CNT_W-1; no wrap.
- match_count is readable at any time and is final at frame_done.

Timing of a normal frame (start high at cycle 0, byte_valid always high):
- LOAD at cycle 1.
- SHIFT at cycles 2 .. 8*FRAME_BYTES+1.
- DRAIN for DET_LAT cycles.
- frame_done at cycle 8*FRAME_BYTES+DET_LAT+2.

Test Plan:
For all scenarios, the bench uses an echo stub for the detector: sd_dout = sd_din delayed DET_LAT, so each frame's count equals the popcount of the bits serialized.
1. Defaults; start at cycle 0; bytes 78,69,68,D2,69 hex, always valid -> sd_din carries 0111100001101001... MSB-first from cycle 2; frame_done at cycle 43; match_count = 19; frame_err = 0.
2. Same bytes; byte_valid held low 6 cycles in LOAD -> sd_reset stays 1 during the wait; SHIFT starts the cycle after the handshake; count = 19; total latency +6.
3. Underrun: supply 78,69, then byte_valid = 0 at the third ready -> abort after 16 bits; frame_done with frame_err = 1; match_count = 8.
4. CNT_W = 4; five bytes FF -> 40 matches; match_count saturates at 15, no wrap.
5. Reset at cycle 20 of scenario 1 -> next cycle IDLE, sd_reset = 1, busy = 0, match_count = 0, no frame_done. A new start then runs scenario 1 cleanly to count 19.
6. start pulsed during SHIFT and DONE -> ignored. Back-to-back start in the cycle after DONE -> second frame begins; sd_reset is high exactly one IDLE cycle plus the LOAD cycle between frames.
